// File: rtl/div_sequencer_4bit_if.sv
// Request/result bundle for the 4-bit restoring divider.
// The master drives the request; the slave (the divider) returns status and results.
interface div_sequencer_4bit_if #(
    parameter int WIDTH = 4
);
    logic             START;
    logic [WIDTH-1:0] DIVIDEND;
    logic [WIDTH-1:0] DIVISOR;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] QUOTIENT;
    logic [WIDTH-1:0] REMAINDER;
    logic             DIV_BY_ZERO;

    modport master (
        output START, DIVIDEND, DIVISOR,
        input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );

    modport slave (
        input  START, DIVIDEND, DIVISOR,
        output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );
endinterface

// File: rtl/div_sequencer_4bit.sv
// Sequential restoring divider: one quotient bit per CALC cycle, MSB first.
// Results land on the outputs only on the final CALC edge (or immediately for a zero divisor).
module div_sequencer_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    div_sequencer_4bit_if.slave bus
);
    localparam int IDXW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] qw_q;
    logic [WIDTH-1:0] rw_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   p_d;
    logic [WIDTH:0]   diff_d;
    logic             borrow_d;
    logic [WIDTH-1:0] rw_d;
    logic [WIDTH-1:0] qw_d;
    logic             step_unused;

    // Restoring step: the borrow of P - divisor decides whether the subtraction is kept.
    always_comb begin
        p_d                 = {rw_q, dvd_q[idx_q]};
        {borrow_d, diff_d}  = {1'b0, p_d} - {2'b00, dvs_q};
        rw_d                = borrow_d ? p_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
        qw_d                = qw_q;
        qw_d[idx_q]         = ~borrow_d;
        // Partial remainder is always below the divisor, so the top difference bit is never needed.
        step_unused         = diff_d[WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qw_q    <= '0;
            rw_q    <= '0;
            idx_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.START) begin
                        dvd_q <= bus.DIVIDEND;
                        dvs_q <= bus.DIVISOR;
                        qw_q  <= '0;
                        rw_q  <= '0;
                        idx_q <= IDXW'(WIDTH - 1);
                        dbz_q <= 1'b0;
                        if (bus.DIVISOR == '0) begin
                            quo_q   <= '1;
                            rem_q   <= bus.DIVIDEND;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    qw_q  <= qw_d;
                    rw_q  <= rw_d;
                    idx_q <= idx_q - IDXW'(1);
                    if (idx_q == '0) begin
                        quo_q   <= qw_d;
                        rem_q   <= rw_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.QUOTIENT    = quo_q;
    assign bus.REMAINDER   = rem_q;
    assign bus.DIV_BY_ZERO = dbz_q;
endmodule

// File: tb/tb_div_sequencer_4bit.sv
// Self-checking bench for div_sequencer_4bit: directed cases, protocol corners,
// an exhaustive operand sweep and randomized operations against an arithmetic model.
module tb_div_sequencer_4bit;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   failures = 0;

    div_sequencer_4bit_if #(.WIDTH(4)) bus ();

    div_sequencer_4bit #(.WIDTH(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    function automatic void model(input int a, input int b, output int q, output int r, output int dz);
        if (b == 0) begin
            q = 15; r = a; dz = 1;
        end else begin
            q = a / b; r = a % b; dz = 0;
        end
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Launches one operation and follows it to DONE; lat counts edges after the accepting edge.
    task automatic do_op(input int a, input int b, output int lat, output int busy_cnt, output bit held_ok);
        logic [3:0] q0, r0;
        q0 = bus.QUOTIENT;
        r0 = bus.REMAINDER;
        bus.START    = 1'b1;
        bus.DIVIDEND = a[3:0];
        bus.DIVISOR  = b[3:0];
        step();
        bus.START = 1'b0;
        lat = 0; busy_cnt = 0; held_ok = 1'b1;
        while (bus.DONE !== 1'b1 && lat < 12) begin
            bus.DIVIDEND = 4'($urandom);
            bus.DIVISOR  = 4'($urandom);
            if (bus.BUSY === 1'b1) busy_cnt++;
            if (bus.QUOTIENT !== q0 || bus.REMAINDER !== r0) held_ok = 1'b0;
            step();
            lat++;
        end
        if (bus.DONE !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.START = 1'b1; bus.DIVIDEND = 4'd5; bus.DIVISOR = 4'd1;
        step(); step();
        checks++;
        if ({bus.BUSY, bus.DONE, bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {bus.BUSY, bus.DONE, bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO});
        end
        bus.START = 1'b0;
        step();
        RESET = 1'b0;
        step();
        checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", bus.BUSY, bus.DONE);
        end
    endtask

    task automatic test_directed();
        int pa[4] = '{13, 15, 7, 0};
        int pb[4] = '{3, 1, 9, 5};
        int lat, bc, q, r, dz;
        bit held;
        for (int i = 0; i < 4; i++) begin
            model(pa[i], pb[i], q, r, dz);
            do_op(pa[i], pb[i], lat, bc, held);
            checks++;
            if (lat != 4) begin failures++; $display("FAIL dir_latency %0d/%0d: got %0d expected 4", pa[i], pb[i], lat); end
            checks++;
            if (bc != 4) begin failures++; $display("FAIL dir_busy_cycles %0d/%0d: got %0d expected 4", pa[i], pb[i], bc); end
            checks++;
            if (bus.QUOTIENT !== 4'(q) || bus.REMAINDER !== 4'(r) || bus.DIV_BY_ZERO !== 1'(dz)) begin
                failures++;
                $display("FAIL dir_result %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%0d",
                         pa[i], pb[i], bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO, q, r, dz);
            end
            checks++;
            if (!held) begin failures++; $display("FAIL dir_outputs_held %0d/%0d: got changed expected stable", pa[i], pb[i]); end
            checks++;
            if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL dir_busy_in_done: got %b expected 0", bus.BUSY); end
            step();
            checks++;
            if (bus.DONE !== 1'b0) begin failures++; $display("FAIL dir_done_width: got %b expected 0", bus.DONE); end
            step(); step(); step();
            checks++;
            if (bus.QUOTIENT !== 4'(q) || bus.REMAINDER !== 4'(r)) begin
                failures++;
                $display("FAIL dir_persist: got q=%0d r=%0d expected q=%0d r=%0d", bus.QUOTIENT, bus.REMAINDER, q, r);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        bit held;
        do_op(9, 0, lat, bc, held);
        checks++;
        if (lat != 0) begin failures++; $display("FAIL dbz_latency: got %0d expected 0", lat); end
        checks++;
        if (bus.BUSY !== 1'b0 || bc != 0) begin failures++; $display("FAIL dbz_busy: got %b/%0d expected 0/0", bus.BUSY, bc); end
        checks++;
        if (bus.QUOTIENT !== 4'hF || bus.REMAINDER !== 4'd9 || bus.DIV_BY_ZERO !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result: got q=%0d r=%0d dz=%b expected q=15 r=9 dz=1", bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO);
        end
        step();
        checks++;
        if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin failures++; $display("FAIL dbz_after: got done=%b busy=%b expected 0/0", bus.DONE, bus.BUSY); end
        step(); step();
        checks++;
        if (bus.DIV_BY_ZERO !== 1'b1) begin failures++; $display("FAIL dbz_persist: got %b expected 1", bus.DIV_BY_ZERO); end
        do_op(8, 2, lat, bc, held);
        checks++;
        if (bus.DIV_BY_ZERO !== 1'b0 || bus.QUOTIENT !== 4'd4 || bus.REMAINDER !== 4'd0) begin
            failures++;
            $display("FAIL dbz_clear: got dz=%b q=%0d r=%0d expected dz=0 q=4 r=0", bus.DIV_BY_ZERO, bus.QUOTIENT, bus.REMAINDER);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int done_cnt = 0;
        int busy_after = 0;
        logic [3:0] q_at = 4'd0, r_at = 4'd0;
        bus.START = 1'b1; bus.DIVIDEND = 4'd14; bus.DIVISOR = 4'd4;
        step();
        bus.START = 1'b0;
        step();
        bus.START = 1'b1; bus.DIVIDEND = 4'd6; bus.DIVISOR = 4'd2;
        step();
        bus.START = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done_cnt > 0 && bus.BUSY === 1'b1) busy_after++;
            if (bus.DONE === 1'b1) begin
                done_cnt++;
                q_at = bus.QUOTIENT; r_at = bus.REMAINDER;
                bus.START = 1'b1;
            end else begin
                bus.START = 1'b0;
            end
            step();
        end
        bus.START = 1'b0;
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (q_at !== 4'd3 || r_at !== 4'd2) begin failures++; $display("FAIL ign_result: got q=%0d r=%0d expected q=3 r=2", q_at, r_at); end
        checks++;
        if (busy_after != 0) begin failures++; $display("FAIL ign_no_second_op: got %0d busy cycles expected 0", busy_after); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, extra = 0;
        bit held;
        do_op(9, 0, lat, bc, held);
        step();
        bus.START = 1'b1; bus.DIVIDEND = 4'd12; bus.DIVISOR = 4'd5;
        step();
        bus.START = 1'b0;
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++;
        if ({bus.BUSY, bus.DONE, bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO} !== 11'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %b expected 0",
                     {bus.BUSY, bus.DONE, bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO});
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) extra++;
            step();
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL rstmid_aborted: got %0d active cycles expected 0", extra); end
        do_op(12, 5, lat, bc, held);
        checks++;
        if (lat != 4 || bus.QUOTIENT !== 4'd2 || bus.REMAINDER !== 4'd2) begin
            failures++;
            $display("FAIL rstmid_restart: got lat=%0d q=%0d r=%0d expected lat=4 q=2 r=2", lat, bus.QUOTIENT, bus.REMAINDER);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int divs[2] = '{3, 0};
        int per[2]  = '{6, 2};
        int q, r, dz;
        int idx[$];
        for (int k = 0; k < 2; k++) begin
            idx.delete();
            bus.START = 1'b1; bus.DIVIDEND = 4'd11; bus.DIVISOR = divs[k][3:0];
            for (int c = 0; c < 20; c++) begin
                step();
                if (bus.DONE === 1'b1) idx.push_back(c);
            end
            bus.START = 1'b0;
            for (int c = 0; c < 8; c++) step();
            checks++;
            if (idx.size() < 3) begin
                failures++;
                $display("FAIL b2b_pulses div=%0d: got %0d expected at least 3", divs[k], idx.size());
            end else begin
                for (int j = 1; j < idx.size(); j++) begin
                    checks++;
                    if (idx[j] - idx[j-1] != per[k]) begin
                        failures++;
                        $display("FAIL b2b_period div=%0d: got %0d expected %0d", divs[k], idx[j] - idx[j-1], per[k]);
                    end
                end
            end
            model(11, divs[k], q, r, dz);
            checks++;
            if (bus.QUOTIENT !== 4'(q) || bus.REMAINDER !== 4'(r) || bus.DIV_BY_ZERO !== 1'(dz)) begin
                failures++;
                $display("FAIL b2b_result div=%0d: got q=%0d r=%0d expected q=%0d r=%0d", divs[k], bus.QUOTIENT, bus.REMAINDER, q, r);
            end
        end
    endtask

    task automatic test_sweep();
        int lat, bc, q, r, dz;
        bit held;
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 16; a++) begin
                model(a, b, q, r, dz);
                do_op(a, b, lat, bc, held);
                checks++;
                if (lat != (b == 0 ? 0 : 4)) begin
                    failures++;
                    $display("FAIL sweep_latency %0d/%0d: got %0d expected %0d", a, b, lat, (b == 0 ? 0 : 4));
                end
                checks++;
                if (bus.QUOTIENT !== 4'(q) || bus.REMAINDER !== 4'(r) || bus.DIV_BY_ZERO !== 1'(dz)) begin
                    failures++;
                    $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%0d",
                             a, b, bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO, q, r, dz);
                end
                step();
            end
        end
    endtask

    task automatic test_random();
        int a, b, lat, bc, q, r, dz, gap;
        bit held;
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            model(a, b, q, r, dz);
            do_op(a, b, lat, bc, held);
            checks++;
            if (bus.QUOTIENT !== 4'(q) || bus.REMAINDER !== 4'(r) || bus.DIV_BY_ZERO !== 1'(dz) || !held) begin
                failures++;
                $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d dz=%b held=%0d expected q=%0d r=%0d dz=%0d held=1",
                         a, b, bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO, held, q, r, dz);
            end
            step();
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    initial begin
        RESET = 1'b1;
        bus.START = 1'b0;
        bus.DIVIDEND = 4'd0;
        bus.DIVISOR = 4'd0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_sequencer_4bit.md
DIV_SEQUENCER_4BIT -- requirements
Module: div_sequencer_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand width; only the value 4 is supported.
REQ-002 Port: CLK  input  1  rising-edge clock for all state.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: START  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: DIVIDEND  input  4  unsigned dividend; captured on the accepting edge.
REQ-006 Port: DIVISOR  input  4  unsigned divisor; captured on the accepting edge.
REQ-007 Port: BUSY  output  1  high while in CALC.
REQ-008 Port: DONE  output  1  one-cycle completion pulse.
REQ-009 Port: QUOTIENT  output  4  last completed quotient, registered.
REQ-010 Port: REMAINDER  output  4  last completed remainder, registered.
REQ-011 Port: DIV_BY_ZERO  output  1  set with DONE when the captured divisor was 0; held until the next accepted START.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE with START=1 at edge E0 SHALL capture DIVIDEND and DIVISOR, clear the working quotient and partial remainder, clear DIV_BY_ZERO, and set the bit index to 3.
REQ-014 At E0, a divisor of nonzero SHALL move the FSM to CALC; a divisor of zero SHALL move it directly to DONE.
REQ-015 Each CALC edge, for bit i from 3 down to 0, SHALL form 5-bit P = {R[3:0], dividend[i]}.
REQ-016 On that edge, if P >= divisor, it SHALL set R = P - divisor and Q[i] = 1; otherwise it SHALL set R = P[3:0] and Q[i] = 0.
REQ-017 The restoring compare SHALL use a 5-bit subtraction whose borrow selects the update; R SHALL always remain below the divisor and fit in 4 bits.
REQ-018 The CALC edge with i=0 (E4) SHALL write the final Q and R to QUOTIENT and REMAINDER and move to DONE.
REQ-019 QUOTIENT and REMAINDER SHALL NOT change at any other time; intermediate values SHALL never appear on them.
REQ-020 Latency: BUSY SHALL be 1 in the four cycles following E0..E3, and DONE SHALL be 1 in exactly the cycle following E4.
REQ-021 DONE SHALL return to IDLE on the next edge; BUSY SHALL be 0 in DONE.
REQ-022 Divide-by-zero: on E0, QUOTIENT SHALL be set to 4'hF, REMAINDER to DIVIDEND, and DIV_BY_ZERO to 1; DONE SHALL assert in the cycle after E0 and BUSY SHALL never assert.
REQ-023 START SHALL be ignored in CALC and DONE, with no queuing; operand input changes SHALL be ignored after E0.
REQ-024 START held high continuously SHALL start a new operation on the first edge back in IDLE, giving a back-to-back period of 6 cycles (2 for divide-by-zero).
REQ-025 Results and DIV_BY_ZERO SHALL persist in IDLE until the next accepted START.

Reset
REQ-026 RESET=1 at a rising edge SHALL force IDLE and set BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0, and clear all working registers.
REQ-027 RESET SHALL take priority over START and over any CALC or DONE activity.
REQ-028 Reset in mid-operation SHALL abort the division with no DONE pulse, and the first post-reset cycle SHALL be IDLE, ready to accept START.

Verification
REQ-029 13/3 started at E0 -> BUSY for 4 cycles, then DONE=1 for one cycle with QUOTIENT=4, REMAINDER=1, DIV_BY_ZERO=0.
REQ-030 15/1 -> Q=15, R=0; 7/9 -> Q=0, R=7; 0/5 -> Q=0, R=0; each with DONE exactly 4 edges after E0.
REQ-031 9/0 -> DONE in the cycle after E0 with Q=4'hF, R=9, DIV_BY_ZERO=1, and BUSY never high.
REQ-032 A START pulse with 6/2 injected during a 14/4 CALC -> single DONE, Q=3, R=2, and no second operation.
REQ-033 RESET asserted at the second CALC edge of 12/5 -> no DONE pulse, all outputs 0; then 12/5 restarted -> Q=2, R=2.
REQ-034 Exhaustive sweep of all 256 {DIVISOR, DIVIDEND} pairs, each awaiting DONE -> QUOTIENT and REMAINDER match integer / and % for nonzero divisors, and match REQ-022 for zero.
